// File: rtl/enc_32x5_scan_if.sv
// rtl/enc_32x5_scan_if.sv - request/index handshake bundle for enc_32x5_scan
// master drives the request side; slave is the encoder.

interface enc_32x5_scan_if #(
  parameter int W = 5,
  parameter int N = 32
);
  logic [N-1:0] req;
  logic         load;
  logic         ack;
  logic [W-1:0] idx;
  logic         valid;
  logic         busy;
  logic         done;
  logic [W:0]   cnt;

  modport master (
    output req, load, ack,
    input  idx, valid, busy, done, cnt
  );

  modport slave (
    input  req, load, ack,
    output idx, valid, busy, done, cnt
  );
endinterface

// File: rtl/enc_32x5_scan.sv
// rtl/enc_32x5_scan.sv - sequential priority encoder, emits set-bit indices lowest first
// Optional feature macro: ENC_MERGE_EN (LOAD during SCAN merges REQ into the pending vector).

module enc_32x5_scan #(
  parameter int W = 5,
  parameter int N = 32
) (
  input logic           clk,
  input logic           reset,
  enc_32x5_scan_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    FIN  = 2'b10
  } state_t;

  localparam logic [W:0] CNT_MAX = (W+1)'(N);

  state_t       state, state_n;
  logic [N-1:0] pend, pend_n, pend_clr;
  logic [W:0]   cnt, cnt_n;
  logic [W-1:0] idx_c;

  // Index of the lowest set bit; zero for an empty vector.
  function automatic logic [W-1:0] lowest_set(input logic [N-1:0] v);
    lowest_set = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = W'(i);
    end
  endfunction

  assign idx_c = lowest_set(pend);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pend  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      pend  <= pend_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    pend_n   = pend;
    cnt_n    = cnt;
    pend_clr = pend;
    case (state)
      IDLE: begin
        if (bus.load) begin
          pend_n  = bus.req;
          cnt_n   = '0;
          state_n = (bus.req != '0) ? SCAN : FIN;
        end
      end
      SCAN: begin
        if (bus.ack) begin
          pend_clr = pend & ~(N'(1) << idx_c);
          if (cnt != CNT_MAX) cnt_n = cnt + (W+1)'(1);
        end
`ifdef ENC_MERGE_EN
        // Merge after clearing, so a re-requested ACKed bit survives and is emitted again.
        if (bus.load) pend_clr = pend_clr | bus.req;
`endif
        pend_n  = pend_clr;
        state_n = (pend_clr != '0) ? SCAN : FIN;
      end
      FIN: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.idx   = idx_c;
  assign bus.valid = (state == SCAN);
  assign bus.busy  = (state == SCAN) || (state == FIN);
  assign bus.done  = (state == FIN);
  assign bus.cnt   = cnt;

endmodule

// File: tb/tb_enc_32x5_scan.sv
// tb/tb_enc_32x5_scan.sv - self-checking bench for enc_32x5_scan
// Table-driven vectors, hand sequences and randomized transactions against a queue model.

module tb_enc_32x5_scan;

  logic clk = 1'b0;
  logic reset = 1'b0;

  enc_32x5_scan_if bus ();

  enc_32x5_scan dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] req;
    int          hold;
    bit          inject;
    int          exp_cnt;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // hold >= 0: ACK low for 'hold' cycles before each index; hold < 0: random ACK.
  task automatic run_txn(input logic [31:0] r, input int hold, input bit inject,
                         input string tag, output int cycles, output int got_cnt);
    int  q[$];
    int  wait_left;
    int  c;
    bit  exp_done;
    bit  a;
    int  pop;
    for (int i = 0; i < 32; i++) if (r[i]) q.push_back(i);
    pop = q.size();
    bus.req  = r;
    bus.load = 1'b1;
    bus.ack  = 1'b0;
    step();
    bus.load  = 1'b0;
    bus.req   = $urandom;
    c         = 1;
    exp_done  = (pop == 0);
    wait_left = hold;
    while (c <= 400) begin
      chk({tag, " done"}, 64'(bus.done), 64'(exp_done));
      if (bus.done) break;
      chk({tag, " valid"}, 64'(bus.valid), 64'(q.size() != 0));
      chk({tag, " busy"}, 64'(bus.busy), 64'd1);
      if (q.size() != 0) chk({tag, " idx"}, 64'(bus.idx), 64'(q[0]));
      if (hold < 0) begin
        a = 1'($urandom_range(0, 1));
      end else if (wait_left > 0) begin
        a = 1'b0;
        wait_left--;
      end else begin
        a = 1'b1;
      end
      bus.ack  = a;
      bus.load = inject && (c == 2);
      bus.req  = 32'h0000_0001;
      exp_done = 1'b0;
      if (a && q.size() != 0) begin
        void'(q.pop_front());
        exp_done  = (q.size() == 0);
        wait_left = hold;
      end
      step();
      c++;
    end
    bus.ack  = 1'b0;
    bus.load = 1'b0;
    if (!bus.done) chk({tag, " timeout"}, 64'd0, 64'd1);
    chk({tag, " cnt"}, 64'(bus.cnt), 64'(pop));
    cycles  = c;
    got_cnt = int'(bus.cnt);
    step();
    chk({tag, " done_pulse"}, 64'(bus.done), 64'd0);
    chk({tag, " idle_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, " idle_valid"}, 64'(bus.valid), 64'd0);
    // ACK in IDLE must be ignored and CNT held.
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    chk({tag, " cnt_hold"}, 64'(bus.cnt), 64'(pop));
    chk({tag, " idle_valid2"}, 64'(bus.valid), 64'd0);
  endtask

  initial begin
    int          cyc;
    int          cn;
    logic [31:0] r;
    int          hold;
    bit          inj;

    vecs[0] = '{32'h8000_0011, 0, 1'b0, 3,  4};
    vecs[1] = '{32'h0000_0000, 0, 1'b0, 0,  1};
    vecs[2] = '{32'h0000_0104, 5, 1'b0, 2,  13};
    vecs[3] = '{32'hFFFF_FFFF, 0, 1'b1, 32, 33};
    vecs[4] = '{32'h8000_0000, 1, 1'b0, 1,  3};
    vecs[5] = '{32'h0000_0001, 0, 1'b1, 1,  2};

    bus.req  = '0;
    bus.load = 1'b0;
    bus.ack  = 1'b0;
    step();
    step();
    chk("rst idx", 64'(bus.idx), 64'd0);
    chk("rst valid", 64'(bus.valid), 64'd0);
    chk("rst busy", 64'(bus.busy), 64'd0);
    chk("rst done", 64'(bus.done), 64'd0);
    chk("rst cnt", 64'(bus.cnt), 64'd0);
    reset = 1'b1;
    step();

`ifndef ENC_MERGE_EN
    for (int i = 0; i < 6; i++) begin
`else
    for (int i = 0; i < 6; i++) if (!vecs[i].inject) begin
`endif
      run_txn(vecs[i].req, vecs[i].hold, vecs[i].inject, $sformatf("vec%0d", i), cyc, cn);
      chk($sformatf("vec%0d cycles", i), 64'(cyc), 64'(vecs[i].exp_cycles));
      chk($sformatf("vec%0d tbl_cnt", i), 64'(cn), 64'(vecs[i].exp_cnt));
    end

    // Asynchronous reset in the middle of a scan.
    bus.req  = 32'hFFFF_FFFF;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    bus.ack  = 1'b1;
    step();
    step();
    step();
    chk("pre_rst idx", 64'(bus.idx), 64'd3);
    #2;
    reset = 1'b0;
    #1;
    chk("async idx", 64'(bus.idx), 64'd0);
    chk("async valid", 64'(bus.valid), 64'd0);
    chk("async busy", 64'(bus.busy), 64'd0);
    chk("async done", 64'(bus.done), 64'd0);
    bus.ack = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("post_rst valid", 64'(bus.valid), 64'd0);
    chk("post_rst idx", 64'(bus.idx), 64'd0);
    chk("post_rst cnt", 64'(bus.cnt), 64'd0);
    step();
    chk("post_rst done", 64'(bus.done), 64'd0);
    chk("post_rst busy", 64'(bus.busy), 64'd0);

`ifdef ENC_MERGE_EN
    bus.req  = 32'h0000_0002;
    bus.load = 1'b1;
    step();
    chk("merge idx1", 64'(bus.idx), 64'd1);
    bus.ack  = 1'b1;
    bus.load = 1'b1;
    bus.req  = 32'h0000_0040;
    step();
    bus.load = 1'b0;
    chk("merge valid", 64'(bus.valid), 64'd1);
    chk("merge idx6", 64'(bus.idx), 64'd6);
    chk("merge nodone", 64'(bus.done), 64'd0);
    step();
    bus.ack = 1'b0;
    chk("merge done", 64'(bus.done), 64'd1);
    chk("merge cnt", 64'(bus.cnt), 64'd2);
    step();
`endif

    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 3))
        0:       r = $urandom;
        1:       r = $urandom & $urandom & $urandom;
        2:       r = 32'h1 << $urandom_range(0, 31);
        default: r = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom | 32'h8000_0001);
      endcase
      hold = $urandom_range(0, 3) - 1;
`ifndef ENC_MERGE_EN
      inj = 1'($urandom_range(0, 1));
`else
      inj = 1'b0;
`endif
      run_txn(r, hold, inj, $sformatf("rnd%0d", k), cyc, cn);
      if (hold >= 0) chk($sformatf("rnd%0d cycles", k), 64'(cyc), 64'($countones(r) * (hold + 1) + 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
